// File: rtl/tx_resp_arbiter.sv
// Response arbiter: merges 1-byte register read data and 2-byte ALU results into the TX FIFO
// write port. Each source has a one-entry holding buffer, and simultaneous requests alternate.
//
// state       | meaning
// IDLE        | no byte in flight; arbitrate between pending buffers
// SEND_REG    | presenting reg_buf, waiting for !wfull
// SEND_ALU_B0 | presenting first ALU byte
// SEND_ALU_B1 | presenting second ALU byte; transfer releases the ALU buffer
module tx_resp_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16,
  parameter bit ALU_MSB_FIRST = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  input  logic                     rd_data_valid_i,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out_i,
  input  logic                     out_valid_i,
  input  logic                     wfull_i,
  input  logic                     ovf_clr_i,
  output logic [DATA_WIDTH-1:0]    tx_p_data_o,
  output logic                     tx_d_vld_o,
  output logic                     arb_busy_o,
  output logic                     ovf_err_o
);

  typedef enum logic [1:0] {IDLE, SEND_REG, SEND_ALU_B0, SEND_ALU_B1} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    reg_buf_q, reg_buf_d;
  logic                     reg_pend_q, reg_pend_d;
  logic [ALU_OUT_WIDTH-1:0] alu_buf_q, alu_buf_d;
  logic                     alu_pend_q, alu_pend_d;
  logic                     last_alu_q, last_alu_d;
  logic                     ovf_err_q, ovf_err_d;

  logic                     xfer, reg_rel, alu_rel, reg_ovf, alu_ovf;
  logic [DATA_WIDTH-1:0]    alu_lo, alu_hi, alu_first, alu_second;

  assign alu_lo     = alu_buf_q[DATA_WIDTH-1:0];
  assign alu_hi     = alu_buf_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
  assign alu_first  = ALU_MSB_FIRST ? alu_hi : alu_lo;
  assign alu_second = ALU_MSB_FIRST ? alu_lo : alu_hi;

  assign xfer    = (state_q != IDLE) && !wfull_i;
  assign reg_rel = xfer && (state_q == SEND_REG);
  assign alu_rel = xfer && (state_q == SEND_ALU_B1);
  assign reg_ovf = rd_data_valid_i && reg_pend_q && !reg_rel;
  assign alu_ovf = out_valid_i && alu_pend_q && !alu_rel;

  always_comb begin
    state_d    = state_q;
    reg_buf_d  = reg_buf_q;
    reg_pend_d = reg_pend_q;
    alu_buf_d  = alu_buf_q;
    alu_pend_d = alu_pend_q;
    last_alu_d = last_alu_q;
    ovf_err_d  = ovf_err_q;

    unique case (state_q)
      IDLE: begin
        // last_grant only moves on contested grants, so back-to-back ties alternate
        if (reg_pend_q && alu_pend_q) begin
          state_d    = last_alu_q ? SEND_REG : SEND_ALU_B0;
          last_alu_d = !last_alu_q;
        end else if (reg_pend_q) begin
          state_d = SEND_REG;
        end else if (alu_pend_q) begin
          state_d = SEND_ALU_B0;
        end
      end
      SEND_REG:    if (xfer) state_d = IDLE;
      SEND_ALU_B0: if (xfer) state_d = SEND_ALU_B1;
      SEND_ALU_B1: if (xfer) state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    if (reg_rel) reg_pend_d = 1'b0;
    if (alu_rel) alu_pend_d = 1'b0;
    if (rd_data_valid_i && !reg_ovf) begin
      reg_buf_d  = rd_data_i;
      reg_pend_d = 1'b1;
    end
    if (out_valid_i && !alu_ovf) begin
      alu_buf_d  = alu_out_i;
      alu_pend_d = 1'b1;
    end

    if (reg_ovf || alu_ovf) ovf_err_d = 1'b1;
    else if (ovf_clr_i)     ovf_err_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      reg_buf_q  <= '0;
      reg_pend_q <= 1'b0;
      alu_buf_q  <= '0;
      alu_pend_q <= 1'b0;
      last_alu_q <= 1'b1;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_buf_q  <= reg_buf_d;
      reg_pend_q <= reg_pend_d;
      alu_buf_q  <= alu_buf_d;
      alu_pend_q <= alu_pend_d;
      last_alu_q <= last_alu_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  always_comb begin
    tx_p_data_o = '0;
    unique case (state_q)
      SEND_REG:    tx_p_data_o = reg_buf_q;
      SEND_ALU_B0: tx_p_data_o = alu_first;
      SEND_ALU_B1: tx_p_data_o = alu_second;
      default:     tx_p_data_o = '0;
    endcase
  end

  assign tx_d_vld_o = xfer;
  assign arb_busy_o = reg_pend_q || alu_pend_q || (state_q != IDLE);
  assign ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Bench for tx_resp_arbiter: two instances (LSB-first and MSB-first ALU order) checked every
// cycle against a transaction-queue model, plus directed byte-stream scenarios.
module tb_tx_resp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic [15:0] alu;
  logic        alu_vld;
  logic        wfull;
  logic        ovf_clr;

  logic [7:0]  data0, data1;
  logic        vld0, vld1, busy0, busy1, ovf0, ovf1;

  tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .ALU_MSB_FIRST(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rd_data_i(rd_data), .rd_data_valid_i(rd_vld),
    .alu_out_i(alu), .out_valid_i(alu_vld), .wfull_i(wfull), .ovf_clr_i(ovf_clr),
    .tx_p_data_o(data0), .tx_d_vld_o(vld0), .arb_busy_o(busy0), .ovf_err_o(ovf0));

  tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .ALU_MSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .rd_data_i(rd_data), .rd_data_valid_i(rd_vld),
    .alu_out_i(alu), .out_valid_i(alu_vld), .wfull_i(wfull), .ovf_clr_i(ovf_clr),
    .tx_p_data_o(data1), .tx_d_vld_o(vld1), .arb_busy_o(busy1), .ovf_err_o(ovf1));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int gcyc    = 0;

  // Model: pending flags + held data per source, and the byte queue of the transaction in flight.
  bit          m_reg_p, m_alu_p, m_last_alu, m_ovf;
  logic [7:0]  m_regb;
  logic [15:0] m_alub;
  logic [7:0]  m_q0[$], m_q1[$];
  int          m_src;

  logic [7:0]  wr0[$], wr1[$];
  int          wt0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reg_p = 0; m_alu_p = 0; m_last_alu = 1; m_ovf = 0;
    m_regb = '0; m_alub = '0; m_src = 0;
    m_q0.delete(); m_q1.delete();
  endtask

  task automatic clear_log();
    wr0.delete(); wr1.delete(); wt0.delete();
  endtask

  task automatic cycle();
    bit         e_vld, idle, rel_reg, rel_alu, ovf_set, grant_reg;
    logic [7:0] e0, e1;
    @(negedge clk);
    e_vld = (m_q0.size() != 0) && !wfull;
    e0    = (m_q0.size() != 0) ? m_q0[0] : 8'h00;
    e1    = (m_q1.size() != 0) ? m_q1[0] : 8'h00;
    chk("vld0", vld0, e_vld);
    chk("vld1", vld1, e_vld);
    chk("data0", data0, e0);
    chk("data1", data1, e1);
    chk("busy0", busy0, m_reg_p | m_alu_p | (m_q0.size() != 0));
    chk("busy1", busy1, m_reg_p | m_alu_p | (m_q1.size() != 0));
    chk("ovf0", ovf0, m_ovf);
    chk("ovf1", ovf1, m_ovf);
    if (vld0 === 1'b1) begin wr0.push_back(data0); wt0.push_back(gcyc); end
    if (vld1 === 1'b1) wr1.push_back(data1);

    idle = (m_q0.size() == 0);
    rel_reg = 0; rel_alu = 0;
    if (e_vld) begin
      void'(m_q0.pop_front());
      void'(m_q1.pop_front());
      if (m_q0.size() == 0) begin
        if (m_src == 1) rel_reg = 1; else rel_alu = 1;
      end
    end
    if (idle && (m_reg_p || m_alu_p)) begin
      if (m_reg_p && m_alu_p) begin
        grant_reg  = m_last_alu;
        m_last_alu = !m_last_alu;
      end else begin
        grant_reg = m_reg_p;
      end
      if (grant_reg) begin
        m_q0.push_back(m_regb); m_q1.push_back(m_regb); m_src = 1;
      end else begin
        m_q0.push_back(m_alub[7:0]);  m_q0.push_back(m_alub[15:8]);
        m_q1.push_back(m_alub[15:8]); m_q1.push_back(m_alub[7:0]);
        m_src = 2;
      end
    end
    ovf_set = (rd_vld && m_reg_p && !rel_reg) || (alu_vld && m_alu_p && !rel_alu);
    if (rel_reg) m_reg_p = 0;
    if (rel_alu) m_alu_p = 0;
    if (rd_vld && !m_reg_p) begin m_regb = rd_data; m_reg_p = 1; end
    if (alu_vld && !m_alu_p) begin m_alub = alu; m_alu_p = 1; end
    if (ovf_set) m_ovf = 1; else if (ovf_clr) m_ovf = 0;

    @(posedge clk);
    #1;
    gcyc++;
    rd_vld = 0; alu_vld = 0; ovf_clr = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1; rd_data = 0; rd_vld = 0; alu = 0; alu_vld = 0; wfull = 0; ovf_clr = 0;
    model_reset();
    #2;
    chk("rst_vld", vld0, 1'b0);
    chk("rst_data", data0, 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ovf", ovf1, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    idle_cycles(2);

    // single register byte
    clear_log(); gcyc = 0;
    rd_data = 8'hA5; rd_vld = 1; cycle();
    idle_cycles(4);
    chk("a5_count", wr0.size(), 1);
    chk("a5_byte", wr0[0], 8'hA5);
    chk("a5_cycle", wt0[0], 2);

    // ALU byte order for both parameter settings
    clear_log(); gcyc = 0;
    alu = 16'h1234; alu_vld = 1; cycle();
    idle_cycles(5);
    chk("alu_cnt", wr0.size(), 2);
    chk("alu_lsb_b0", wr0[0], 8'h34);
    chk("alu_lsb_b1", wr0[1], 8'h12);
    chk("alu_msb_b0", wr1[0], 8'h12);
    chk("alu_msb_b1", wr1[1], 8'h34);
    chk("alu_t0", wt0[0], 2);
    chk("alu_t1", wt0[1], 3);

    // tie, then repeated tie alternates
    clear_log();
    rd_data = 8'h11; rd_vld = 1; alu = 16'hBEEF; alu_vld = 1; cycle();
    idle_cycles(8);
    rd_data = 8'h11; rd_vld = 1; alu = 16'hBEEF; alu_vld = 1; cycle();
    idle_cycles(8);
    chk("tie_cnt", wr0.size(), 6);
    chk("tie1_a", wr0[0], 8'h11);
    chk("tie1_b", wr0[1], 8'hEF);
    chk("tie1_c", wr0[2], 8'hBE);
    chk("tie2_a", wr0[3], 8'hEF);
    chk("tie2_b", wr0[4], 8'hBE);
    chk("tie2_c", wr0[5], 8'h11);

    // ALU pair stalled by wfull between its bytes
    clear_log(); gcyc = 0;
    for (int c = 0; c < 12; c++) begin
      wfull = (c >= 3 && c <= 7);
      if (c == 0) begin alu = 16'hCAFE; alu_vld = 1; end
      cycle();
    end
    wfull = 0;
    chk("stall_cnt", wr0.size(), 2);
    chk("stall_b0", wr0[0], 8'hFE);
    chk("stall_b1", wr0[1], 8'hCA);
    chk("stall_t0", wt0[0], 2);
    chk("stall_t1", wt0[1], 8);

    // overflow while register byte is held under wfull
    clear_log();
    for (int c = 0; c < 10; c++) begin
      wfull = (c < 6);
      if (c == 0) begin rd_data = 8'h11; rd_vld = 1; end
      if (c == 3) begin rd_data = 8'h22; rd_vld = 1; end
      cycle();
    end
    chk("ovf_cnt", wr0.size(), 1);
    chk("ovf_byte", wr0[0], 8'h11);
    chk("ovf_set", ovf0, 1'b1);
    ovf_clr = 1; cycle();
    idle_cycles(1);
    chk("ovf_clr", ovf0, 1'b0);

    // reset during the second ALU byte
    clear_log();
    alu = 16'h5A3C; alu_vld = 1; cycle();
    idle_cycles(2);
    #2 rst = 1;
    #1;
    chk("mrst_vld", vld0, 1'b0);
    chk("mrst_data", data0, 8'h00);
    chk("mrst_busy", busy0, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    clear_log();
    idle_cycles(6);
    chk("mrst_resid", wr0.size(), 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wfull   = ($urandom_range(0, 99) < 30);
      rd_vld  = ($urandom_range(0, 99) < 20);
      rd_data = 8'($urandom);
      alu_vld = ($urandom_range(0, 99) < 15);
      alu     = 16'($urandom);
      ovf_clr = ($urandom_range(0, 99) < 5);
      cycle();
    end
    wfull = 0;
    idle_cycles(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
